// File: rtl/load_align_unit.sv
// Load data alignment unit: tracks one outstanding data-memory read, extracts and
// extends the addressed byte/half/word. Optional macro: LOAD_MISALIGN_TRAP_EN.
module load_align_unit #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  rd_addr,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt_q, cnt_nx;
  logic [2:0]  sel_q;
  logic [1:0]  addr_q;
  logic [4:0]  rd_q;
  logic        accept;
  logic        illegal;
  logic        misalign;
  logic        resp_take;
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  logic [31:0] ext_data;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign stall     = (state != IDLE);
  assign resp_take = (state == WAIT) && dmem_rvalid;
  assign illegal   = (load_sel == 3'b011) || (load_sel[2:1] == 2'b11);

`ifdef LOAD_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (load_sel[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = '0;
          state_nx = (illegal || misalign) ? ERR : WAIT;
        end
      end
      WAIT: begin
        // A response on the last allowed cycle takes priority over the timeout.
        if (dmem_rvalid) begin
          state_nx = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          state_nx = ERR;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Half extraction for addr 11 yields the top byte zero-padded, as a right shift would.
  always_comb begin
    half_v = '0;
    case (addr_q)
      2'd0: half_v = dmem_rdata[15:0];
      2'd1: half_v = dmem_rdata[23:8];
      2'd2: half_v = dmem_rdata[31:16];
      2'd3: half_v = {8'h00, dmem_rdata[31:24]};
      default: half_v = '0;
    endcase
  end

  assign byte_v = half_v[7:0];

  always_comb begin
    ext_data = dmem_rdata;
    case (sel_q)
      3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_data = {{16{half_v[15]}}, half_v};
      3'b100:  ext_data = {24'h000000, byte_v};
      3'b101:  ext_data = {16'h0000, half_v};
      default: ext_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      load_err <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
    end else begin
      state    <= state_nx;
      cnt_q    <= cnt_nx;
      wb_valid <= resp_take;
      load_err <= (state != ERR) && (state_nx == ERR);
      if (accept) begin
        sel_q  <= load_sel;
        addr_q <= addr_lo;
        rd_q   <= rd_addr;
      end
      if (resp_take) begin
        wb_data <= ext_data;
        wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: vector table plus scoreboard of expected
// writeback/error pulses with their cycle numbers, and reset corner sequences.
module tb_load_align_unit;

  localparam int unsigned MAX_WAIT = 8;

`ifdef LOAD_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  load_sel;
  logic [1:0]  addr_lo;
  logic [4:0]  rd_addr;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        load_err;

  load_align_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .load_sel(load_sel), .addr_lo(addr_lo), .rd_addr(rd_addr),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  addr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          d;        // cycle (relative to request) of dmem_rvalid, 0 = none
    int          out_cyc;  // cycle of expected wb_valid / load_err
    logic        err;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [1:0] a, input logic [4:0] rd,
                              input logic [31:0] rdata, input int d, input int oc,
                              input logic err, input logic [31:0] data);
    vec_t v;
    v.sel = sel; v.addr = a; v.rd = rd; v.rdata = rdata;
    v.d = d; v.out_cyc = oc; v.err = err; v.data = data;
    return v;
  endfunction

  // Misaligned access: traps in the trap build, completes normally otherwise.
  function automatic vec_t mis(input logic [2:0] sel, input logic [1:0] a, input logic [4:0] rd,
                               input logic [31:0] rdata, input logic [31:0] data);
    if (TRAP) return mk(sel, a, rd, rdata, 1, 1, 1'b1, 32'h0);
    return mk(sel, a, rd, rdata, 1, 2, 1'b0, data);
  endfunction

  // Scoreboard monitor: every wb_valid/load_err pulse must match the queue head.
  always @(negedge clk) begin
    if (wb_valid || load_err) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got wb_valid=%b load_err=%b expected none (cycle %0d)",
                 wb_valid, load_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_valid !== !e.err || load_err !== e.err || cyc != e.cyc ||
            (!e.err && (wb_data !== e.data || wb_rd !== e.rd))) begin
          n_fail++;
          $display("FAIL wb_pulse: got valid=%b err=%b data=%h rd=%0d cyc=%0d expected valid=%b err=%b data=%h rd=%0d cyc=%0d",
                   wb_valid, load_err, wb_data, wb_rd, cyc, !e.err, e.err, e.data, e.rd, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_pulse: got none expected err=%b at cycle %0d", sb[0].err, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.err = v.err; e.data = v.data; e.rd = v.rd; e.cyc = cyc + v.out_cyc;
    sb.push_back(e);
    req_valid = 1'b1; load_sel = v.sel; addr_lo = v.addr; rd_addr = v.rd;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    chk("stall_idle", stall, 0);
    tick();
    req_valid = 1'b0; load_sel = 3'b000; addr_lo = 2'b00; rd_addr = 5'd0;
    for (int c = 1; c < v.out_cyc; c++) begin
      if (c == v.d) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = v.rdata;
      end
      @(negedge clk);
      chk("stall_wait", stall, 1);
      tick();
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
    end
    if (v.err) begin
      @(negedge clk);
      chk("stall_err", stall, 1);
      chk("req_ready_err", req_ready, 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; load_sel = '0; addr_lo = '0; rd_addr = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;

    tbl.push_back(mk(3'b000, 2'd3, 5'd5,  32'h80FF1234, 1, 2, 1'b0, 32'hFFFFFF80));
    tbl.push_back(mk(3'b100, 2'd3, 5'd6,  32'h80FF1234, 1, 2, 1'b0, 32'h00000080));
    tbl.push_back(mk(3'b001, 2'd2, 5'd7,  32'h80010000, 1, 2, 1'b0, 32'hFFFF8001));
    tbl.push_back(mk(3'b101, 2'd2, 5'd8,  32'h80010000, 1, 2, 1'b0, 32'h00008001));
    tbl.push_back(mk(3'b000, 2'd0, 5'd9,  32'h80FF1234, 2, 3, 1'b0, 32'h00000034));
    tbl.push_back(mk(3'b000, 2'd2, 5'd10, 32'h80FF1234, 1, 2, 1'b0, 32'hFFFFFFFF));
    tbl.push_back(mk(3'b100, 2'd1, 5'd11, 32'h80FF1234, 1, 2, 1'b0, 32'h00000012));
    tbl.push_back(mis(3'b001, 2'd3, 5'd12, 32'h80FF1234, 32'h00000080));
    tbl.push_back(mis(3'b010, 2'd1, 5'd13, 32'h11223344, 32'h11223344));
    tbl.push_back(mis(3'b001, 2'd1, 5'd14, 32'h80FF1234, 32'hFFFFFF12));
    tbl.push_back(mis(3'b101, 2'd1, 5'd15, 32'h80FF1234, 32'h0000FF12));
    tbl.push_back(mis(3'b010, 2'd2, 5'd16, 32'hDEADBEEF, 32'hDEADBEEF));
    tbl.push_back(mk(3'b010, 2'd0, 5'd17, 32'hDEADBEEF, 3, 4, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(3'b011, 2'd0, 5'd18, 32'h12345678, 1, 1, 1'b1, 32'h0));
    tbl.push_back(mk(3'b110, 2'd0, 5'd19, 32'h12345678, 1, 1, 1'b1, 32'h0));
    tbl.push_back(mk(3'b111, 2'd0, 5'd20, 32'h12345678, 1, 1, 1'b1, 32'h0));
    tbl.push_back(mk(3'b010, 2'd0, 5'd21, 32'hCAFEF00D, 0, MAX_WAIT + 1, 1'b1, 32'h0));
    tbl.push_back(mk(3'b010, 2'd0, 5'd22, 32'h0BADC0DE, MAX_WAIT, MAX_WAIT + 1, 1'b0, 32'h0BADC0DE));
    tbl.push_back(mk(3'b101, 2'd0, 5'd23, 32'h1234ABCD, 1, 2, 1'b0, 32'h0000ABCD));
    tbl.push_back(mk(3'b001, 2'd2, 5'd24, 32'h7FFF0000, 1, 2, 1'b0, 32'h00007FFF));
    tbl.push_back(mk(3'b001, 2'd0, 5'd25, 32'h00008000, 1, 2, 1'b0, 32'hFFFF8000));

    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_load_err", load_err, 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset during WAIT abandons the load; a later response is dropped.
    req_valid = 1'b1; load_sel = 3'b010; addr_lo = 2'd0; rd_addr = 5'd30;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_stall_wait", stall, 1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_wb_data", wb_data, 0);
    chk("abort_wb_rd", wb_rd, 0);
    chk("abort_stall", stall, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_load_err", load_err, 0);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
    tick();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_wb_valid", wb_valid, 0);
    chk("stray_stall", stall, 0);
    chk("stray_req_ready", req_ready, 1);
    tick();
    run_vec(mk(3'b000, 2'd1, 5'd31, 32'h0000F100, 1, 2, 1'b0, 32'hFFFFFFF1));

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Load-side counterpart of the store data alignment path, sitting in the MEM/WB boundary of the pipeline. It tracks an outstanding data-memory read and extracts the addressed byte, halfword or word from the returned 32-bit word. It then sign- or zero-extends the value and presents it to writeback with a one-cycle valid pulse. It stalls the pipeline while a load is outstanding and flags illegal, misaligned or timed-out loads.

## Interface
Parameters:
- MAX_WAIT, 8: maximum cycles spent in WAIT before a timeout error; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  load issued in the MEM stage this cycle.
- req_ready  out  1  high in IDLE and rst_n=1; the request is accepted when req_valid && req_ready.
- load_sel  in  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal.
- addr_lo  in  2  effective address bits [1:0] (alu_out[1:0]).
- rd_addr  in  5  destination register.
- dmem_rvalid  in  1  read data valid from data memory.
- dmem_rdata  in  32  read word; byte 0 is [7:0].
- wb_valid  out  1  one-cycle pulse; wb_data and wb_rd are valid.
- wb_rd  out  5  captured rd_addr.
- wb_data  out  32  aligned and extended load result.
- stall  out  1  high whenever state != IDLE.
- load_err  out  1  one-cycle error pulse.

## Operation
- States: IDLE, WAIT, ERR.
- On an accepted request, capture load_sel, addr_lo and rd_addr, then classify:
  - An illegal load_sel always goes to ERR.
  - A misaligned access goes to ERR only when LOAD_MISALIGN_TRAP_EN is defined.
  - Otherwise go to WAIT and clear the wait counter.
- WAIT:
  - On dmem_rvalid, register the result, pulse wb_valid in the next cycle, and return to IDLE.
  - Without dmem_rvalid, increment the counter. When the counter equals MAX_WAIT-1 and dmem_rvalid is low, go to ERR.
  - If dmem_rvalid arrives on the final allowed cycle, it wins over the timeout.
- ERR: load_err=1 and wb_valid=0 for exactly one cycle, then IDLE.
- dmem_rvalid is ignored in IDLE and ERR; stray responses are dropped silently.
- Extraction uses s = addr_lo:
  - Byte: dmem_rdata >> (8*s), bits [7:0].
  - Half: (dmem_rdata >> (8*s)) bits [15:0]. For s=11 this gives {8'h00, rdata[31:24]} before extension.
  - Word: dmem_rdata unchanged; addr_lo is ignored.
- Extension: LB/LH replicate bit 7/15 respectively. LBU/LHU zero-fill.
- wb_data and wb_rd hold their values between pulses; only wb_valid qualifies them.
- Reset (rst_n=0 at an edge):
  - State becomes IDLE and the counter is cleared.
  - wb_valid=0, load_err=0, wb_data=0, wb_rd=0, stall=0.
  - req_ready is forced to 0 while rst_n=0.
  - An in-flight load is abandoned and never produces wb_valid.

## Timing
- Request accepted in cycle 0. The earliest accepted dmem_rvalid is cycle 1, giving the earliest wb_valid in cycle 2.
- General latency: dmem_rvalid in cycle N gives wb_valid in cycle N+1. wb_valid, wb_data, wb_rd and load_err are all registered.
- stall is high from cycle 1 through the cycle in which dmem_rvalid is sampled, or through the ERR cycle.
- Back-to-back: the wb_valid cycle is an IDLE cycle, so req_ready=1 and a new request is accepted in the same cycle.
- Timeout: with no response, WAIT lasts MAX_WAIT cycles (cycles 1..MAX_WAIT). load_err pulses in cycle MAX_WAIT+1, and the unit is back in IDLE in cycle MAX_WAIT+2.
- Error at request: load_err pulses in cycle 1 and the unit is back in IDLE in cycle 2.

## Configuration
- LOAD_MISALIGN_TRAP_EN defined: these accesses go to ERR with a load_err pulse, no wb_valid, and no wait for memory:
  - LH/LHU with addr_lo[0]=1.
  - LW with addr_lo!=00.
- Undefined: misaligned accesses complete normally using the extraction rules above, and load_err arises only from illegal load_sel or timeout.

## Test plan
- LB, addr_lo=11, rdata=0x80FF1234, rvalid in cycle 1 -> wb_valid in cycle 2, wb_data=0xFFFFFF80; LBU with the same stimulus -> 0x00000080.
- LH and LHU, addr_lo=10, rdata=0x80010000 -> LH gives wb_data=0xFFFF8001; LHU gives 0x00008001; wb_rd equals the captured rd_addr.
- LW, req in cycle 0, rvalid in cycle 3 with 0xDEADBEEF -> stall high in cycles 1-3, wb_valid only in cycle 4 with 0xDEADBEEF; a second request in cycle 4 is accepted.
- MAX_WAIT=8, no rvalid -> load_err in cycle 9 only, no wb_valid, req_ready high in cycle 10; with rvalid in cycle 8 -> wb_valid in cycle 9 and no error.
- LW, addr_lo=01, rdata=0x11223344:
  - With LOAD_MISALIGN_TRAP_EN: load_err in cycle 1, no wb_valid.
  - Without it: wb_data=0x11223344.
  - load_sel=011 -> load_err in cycle 1 in both builds.
- rst_n low during WAIT, then rvalid after reset -> no wb_valid, all outputs 0; a following LB completes normally.
